// File: rtl/usb_buffer_arbiter_pkg.sv
`default_nettype none
// ============================================================
// Module  : usb_buffer_arbiter_pkg
// Brief   : State encoding and address map for the buffer arbiter
// Rev     : 1.0 - initial release
// ============================================================
package usb_buffer_arbiter_pkg;

    typedef enum logic [1:0] {
        USB_OWNS  = 2'd0,
        CORE_OWNS = 2'd1,
        RELEASE   = 2'd2
    } arb_state_t;

    localparam logic [31:0] c_buffer_base     = 32'hc000_0000;
    localparam logic [31:0] c_control_address = 32'h8000_0014;

endpackage
`default_nettype wire

// File: rtl/usb_buffer_watchdog.sv
`default_nettype none
// ============================================================
// Module  : usb_buffer_watchdog
// Brief   : Core-ownership cycle counter with expire pulse
// Rev     : 1.0 - initial release
// ============================================================
module usb_buffer_watchdog #(
    parameter int TIMEOUT_CYCLES = 24000000
) (
    input  logic clk24,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // A zero timeout disables expiry entirely
    assign expire = (TIMEOUT_CYCLES != 0) && enable && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/usb_buffer_arbiter.sv
`default_nettype none
// ============================================================
// Module  : usb_buffer_arbiter
// Brief   : Buffer ownership FSM between core and usb module
// Rev     : 1.0 - initial release
// ============================================================
module usb_buffer_arbiter
    import usb_buffer_arbiter_pkg::*;
#(
    parameter logic [31:0] BUFFER_BASE     = c_buffer_base,
    parameter int          BUFFER_BYTES    = 1024,
    parameter logic [31:0] CONTROL_ADDRESS = c_control_address,
    parameter int          TIMEOUT_CYCLES  = 24000000,
    localparam int         ADDR_W          = $clog2(BUFFER_BYTES / 4)
) (
    input  logic              clk24,
    input  logic              rst_n,
    input  logic [31:0]       core_address,
    input  logic [31:0]       core_write_value,
    input  logic [3:0]        core_write_sections,
    input  logic [ADDR_W-1:0] usb_buffer_address,
    input  logic [31:0]       usb_write_value,
    input  logic              usb_write_enable,
    input  logic              got_usb_packet,
    input  logic [15:0]       usb_usb_control,
    output logic [ADDR_W-1:0] buffer_address,
    output logic [31:0]       buffer_write_value,
    output logic [3:0]        buffer_write_sections,
    output logic              usb_packet_ready,
    output logic [15:0]       usb_control,
    output logic              timed_out,
    output logic [7:0]        dropped_packets
);

    arb_state_t        r_state;
    logic              r_ready;
    logic [15:0]       r_usb_control;
    logic              r_timed_out;
    logic [7:0]        r_dropped;

    logic              w_buf_hit;
    logic              w_ctrl_write;
    logic              w_core_owns;
    logic              w_expire;
    logic [ADDR_W-1:0] w_core_word;

    assign w_core_owns  = (r_state == CORE_OWNS);
    assign w_buf_hit    = ({1'b0, core_address} >= {1'b0, BUFFER_BASE}) &&
                          ({1'b0, core_address} <  ({1'b0, BUFFER_BASE} + 33'(BUFFER_BYTES)));
    assign w_ctrl_write = w_core_owns &&
                          (core_address[31:2] == CONTROL_ADDRESS[31:2]) &&
                          (|core_write_sections[1:0]);
    // Buffer base is word aligned, so no borrow crosses into the word index
    assign w_core_word  = core_address[ADDR_W+1:2] - BUFFER_BASE[ADDR_W+1:2];

    usb_buffer_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk24 (clk24),
        .rst_n (rst_n),
        .clear (!w_core_owns),
        .enable(w_core_owns),
        .expire(w_expire)
    );

    always_comb begin
        buffer_address        = usb_buffer_address;
        buffer_write_value    = usb_write_value;
        buffer_write_sections = 4'b0000;
        case (r_state)
            USB_OWNS: begin
                buffer_write_sections = usb_write_enable ? 4'b1111 : 4'b0000;
            end
            CORE_OWNS: begin
                buffer_address        = w_core_word;
                buffer_write_value    = core_write_value;
                buffer_write_sections = w_buf_hit ? core_write_sections : 4'b0000;
            end
            default: begin
                // Turnaround keeps the core address so a pending read completes
                buffer_address     = w_core_word;
                buffer_write_value = core_write_value;
            end
        endcase
    end

    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= USB_OWNS;
            r_ready       <= 1'b0;
            r_usb_control <= 16'h0000;
            r_timed_out   <= 1'b0;
            r_dropped     <= 8'h00;
        end else begin
            if (got_usb_packet && (r_state != USB_OWNS) && (r_dropped != 8'hff)) begin
                r_dropped <= r_dropped + 8'h01;
            end
            case (r_state)
                USB_OWNS: begin
                    if (got_usb_packet) begin
                        r_usb_control <= usb_usb_control;
                        r_ready       <= 1'b1;
                        r_state       <= CORE_OWNS;
                    end
                end
                CORE_OWNS: begin
                    if (w_ctrl_write) begin
                        if (core_write_sections[0]) r_usb_control[7:0]  <= core_write_value[7:0];
                        if (core_write_sections[1]) r_usb_control[15:8] <= core_write_value[15:8];
                        r_timed_out <= 1'b0;
                        r_ready     <= 1'b0;
                        r_state     <= RELEASE;
                    end else if (w_expire) begin
                        r_usb_control <= 16'h0000;
                        r_timed_out   <= 1'b1;
                        r_ready       <= 1'b0;
                        r_state       <= RELEASE;
                    end
                end
                RELEASE: begin
                    r_state <= USB_OWNS;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= USB_OWNS;
                end
            endcase
        end
    end

    assign usb_packet_ready = r_ready;
    assign usb_control      = r_usb_control;
    assign timed_out        = r_timed_out;
    assign dropped_packets  = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_usb_buffer_arbiter.sv
`default_nettype none
// ============================================================
// Module  : tb_usb_buffer_arbiter
// Brief   : Directed self-checking bench for usb_buffer_arbiter
// Rev     : 1.0 - initial release
// ============================================================
module tb_usb_buffer_arbiter;

    localparam logic [31:0] c_ctrl = 32'h8000_0014;

    logic        clk24 = 1'b0;
    logic        rst_n;
    logic [31:0] core_address;
    logic [31:0] core_write_value;
    logic [3:0]  core_write_sections;
    logic [7:0]  usb_buffer_address;
    logic [31:0] usb_write_value;
    logic        usb_write_enable;
    logic        got_usb_packet;
    logic        got2;
    logic [15:0] usb_usb_control;

    logic [7:0]  buffer_address, buffer_address2;
    logic [31:0] buffer_write_value, buffer_write_value2;
    logic [3:0]  buffer_write_sections, buffer_write_sections2;
    logic        usb_packet_ready, ready2;
    logic [15:0] usb_control, control2;
    logic        timed_out, timed2;
    logic [7:0]  dropped_packets, dropped2;

    int checks   = 0;
    int failures = 0;

    always #5 clk24 = ~clk24;

    usb_buffer_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk24(clk24), .rst_n(rst_n),
        .core_address(core_address), .core_write_value(core_write_value),
        .core_write_sections(core_write_sections),
        .usb_buffer_address(usb_buffer_address), .usb_write_value(usb_write_value),
        .usb_write_enable(usb_write_enable), .got_usb_packet(got_usb_packet),
        .usb_usb_control(usb_usb_control),
        .buffer_address(buffer_address), .buffer_write_value(buffer_write_value),
        .buffer_write_sections(buffer_write_sections),
        .usb_packet_ready(usb_packet_ready), .usb_control(usb_control),
        .timed_out(timed_out), .dropped_packets(dropped_packets)
    );

    // Watchdog disabled instance used for the saturation test
    usb_buffer_arbiter #(.TIMEOUT_CYCLES(0)) dut_nowd (
        .clk24(clk24), .rst_n(rst_n),
        .core_address(core_address), .core_write_value(core_write_value),
        .core_write_sections(core_write_sections),
        .usb_buffer_address(usb_buffer_address), .usb_write_value(usb_write_value),
        .usb_write_enable(usb_write_enable), .got_usb_packet(got2),
        .usb_usb_control(usb_usb_control),
        .buffer_address(buffer_address2), .buffer_write_value(buffer_write_value2),
        .buffer_write_sections(buffer_write_sections2),
        .usb_packet_ready(ready2), .usb_control(control2),
        .timed_out(timed2), .dropped_packets(dropped2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk24);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        core_address = 32'h0; core_write_value = 32'h0; core_write_sections = 4'h0;
        usb_buffer_address = 8'h0; usb_write_value = 32'h0; usb_write_enable = 1'b0;
        got_usb_packet = 1'b0; got2 = 1'b0; usb_usb_control = 16'h0;
        step(); step();
        chk("rst_ready", 32'(usb_packet_ready), 32'h0);
        chk("rst_control", 32'(usb_control), 32'h0);
        chk("rst_timed_out", 32'(timed_out), 32'h0);
        chk("rst_dropped", 32'(dropped_packets), 32'h0);
        chk("rst_sections", 32'(buffer_write_sections), 32'h0);
        rst_n = 1'b1;

        // usb module owns the buffer; core control write is ignored
        usb_write_enable = 1'b1; usb_buffer_address = 8'd3; usb_write_value = 32'hdead_beef;
        core_address = c_ctrl; core_write_value = 32'h0000_00ff; core_write_sections = 4'b0011;
        #1;
        chk("usb_addr", 32'(buffer_address), 32'd3);
        chk("usb_sections", 32'(buffer_write_sections), 32'hf);
        chk("usb_value", buffer_write_value, 32'hdead_beef);
        step();
        chk("usb_ctrl_ignored_ready", 32'(usb_packet_ready), 32'h0);
        chk("usb_ctrl_ignored_control", 32'(usb_control), 32'h0);
        core_write_sections = 4'b0000;

        // Packet handoff
        got_usb_packet = 1'b1; usb_usb_control = 16'h1234;
        step();
        got_usb_packet = 1'b0;
        #1;
        chk("handoff_ready", 32'(usb_packet_ready), 32'h1);
        chk("handoff_control", 32'(usb_control), 32'h1234);
        chk("core_ignores_usb_we", 32'(buffer_write_sections), 32'h0);

        // Core buffer decode and range boundaries
        usb_write_enable = 1'b0;
        core_address = 32'hc000_0008; core_write_value = 32'h1122_3344; core_write_sections = 4'hf;
        #1;
        chk("core_addr", 32'(buffer_address), 32'd2);
        chk("core_sections", 32'(buffer_write_sections), 32'hf);
        chk("core_value", buffer_write_value, 32'h1122_3344);
        core_address = 32'hc000_03fc; #1;
        chk("core_top_addr", 32'(buffer_address), 32'hff);
        chk("core_top_sections", 32'(buffer_write_sections), 32'hf);
        core_address = 32'hc000_0400; #1;
        chk("core_above_range", 32'(buffer_write_sections), 32'h0);
        core_address = 32'hbfff_fffc; #1;
        chk("core_below_range", 32'(buffer_write_sections), 32'h0);
        core_write_sections = 4'h0;

        // Packets while core owns are dropped
        got_usb_packet = 1'b1; usb_usb_control = 16'hffff;
        step(); step(); step();
        got_usb_packet = 1'b0;
        #1;
        chk("drop_count", 32'(dropped_packets), 32'd3);
        chk("drop_control_kept", 32'(usb_control), 32'h1234);

        // Control write releases the buffer through one turnaround cycle
        core_address = c_ctrl; core_write_value = 32'h0000_00ab; core_write_sections = 4'b0011;
        #1;
        chk("ctrl_not_buffer", 32'(buffer_write_sections), 32'h0);
        step();
        core_address = 32'hc000_0008; core_write_sections = 4'hf; usb_write_enable = 1'b1;
        #1;
        chk("release_control", 32'(usb_control), 32'h00ab);
        chk("release_ready", 32'(usb_packet_ready), 32'h0);
        chk("release_sections", 32'(buffer_write_sections), 32'h0);
        step();
        core_write_sections = 4'h0; usb_buffer_address = 8'd5;
        #1;
        chk("back_usb_addr", 32'(buffer_address), 32'd5);
        chk("back_usb_sections", 32'(buffer_write_sections), 32'hf);
        usb_write_enable = 1'b0;

        // Asynchronous reset while core owns
        got_usb_packet = 1'b1; usb_usb_control = 16'h4321;
        step();
        got_usb_packet = 1'b0;
        #1;
        chk("pre_reset_ready", 32'(usb_packet_ready), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_ready", 32'(usb_packet_ready), 32'h0);
        chk("async_rst_control", 32'(usb_control), 32'h0);
        chk("async_rst_dropped", 32'(dropped_packets), 32'h0);
        step();
        rst_n = 1'b1;

        // Watchdog expiry after 16 idle cycles
        got_usb_packet = 1'b1; usb_usb_control = 16'h5a5a;
        step();
        got_usb_packet = 1'b0;
        repeat (15) step();
        chk("wd_pre_ready", 32'(usb_packet_ready), 32'h1);
        chk("wd_pre_timed_out", 32'(timed_out), 32'h0);
        chk("wd_pre_control", 32'(usb_control), 32'h5a5a);
        step();
        chk("wd_ready", 32'(usb_packet_ready), 32'h0);
        chk("wd_control", 32'(usb_control), 32'h0);
        chk("wd_timed_out", 32'(timed_out), 32'h1);
        step();
        chk("wd_sticky", 32'(timed_out), 32'h1);
        got_usb_packet = 1'b1; usb_usb_control = 16'h1111;
        step();
        got_usb_packet = 1'b0;
        core_address = c_ctrl; core_write_value = 32'h0000_3377; core_write_sections = 4'b0001;
        step();
        core_write_sections = 4'h0;
        #1;
        chk("wd_clear_timed_out", 32'(timed_out), 32'h0);
        chk("low_lane_write", 32'(usb_control), 32'h1177);

        // Expiry cycle coincides with control write: the write wins
        step();
        got_usb_packet = 1'b1; usb_usb_control = 16'h9999;
        step();
        got_usb_packet = 1'b0;
        repeat (15) step();
        core_address = c_ctrl; core_write_value = 32'h0000_0055; core_write_sections = 4'b0011;
        step();
        core_write_sections = 4'h0;
        #1;
        chk("tie_control", 32'(usb_control), 32'h0055);
        chk("tie_timed_out", 32'(timed_out), 32'h0);
        chk("tie_ready", 32'(usb_packet_ready), 32'h0);

        // Drop counter saturation with watchdog disabled
        got2 = 1'b1; usb_usb_control = 16'hbeef;
        step();
        #1;
        chk("nowd_ready", 32'(ready2), 32'h1);
        chk("nowd_control", 32'(control2), 32'hbeef);
        usb_usb_control = 16'h0000;
        repeat (300) step();
        got2 = 1'b0;
        #1;
        chk("sat_dropped", 32'(dropped2), 32'hff);
        chk("sat_control", 32'(control2), 32'hbeef);
        chk("sat_ready", 32'(ready2), 32'h1);
        chk("sat_no_timeout", 32'(timed2), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usb_buffer_arbiter.md
Name: usb_buffer_arbiter

Overview:
Owns the USB data buffer handshake between the core (clk24 domain) and the usb module. It replaces the inline ownership logic in the top level with an explicit FSM. The FSM covers buffer address/write steering, the latched usb_control register and a one-cycle release turnaround. A core-ownership watchdog forcibly returns the buffer to the usb module if firmware stalls.

Parameters:
BUFFER_BASE, 32'hc0000000, core byte address of buffer word 0
BUFFER_BYTES, 1024, buffer size in bytes; address width = $clog2(BUFFER_BYTES/4)
CONTROL_ADDRESS, 32'h80000014, core address of usb_control register (word-decoded)
TIMEOUT_CYCLES, 24000000, clk24 cycles the core may hold the buffer (1 s); 0 disables watchdog

Ports:
clk24  input  1  core clock
rst_n  input  1  asynchronous active-low reset
core_address  input  32  core memory address
core_write_value  input  32  lane-aligned write data (already shifted)
core_write_sections  input  4  byte-lane write enables (already shifted)
usb_buffer_address  input  8  usb module buffer word address
usb_write_value  input  32  usb module write data
usb_write_enable  input  1  usb module full-word write
got_usb_packet  input  1  usb module single-cycle pulse: packet in buffer
usb_usb_control  input  16  control word from usb module, valid with got_usb_packet
buffer_address  output  8  word address to buffer RAM
buffer_write_value  output  32  write data to buffer RAM
buffer_write_sections  output  4  byte-lane enables to buffer RAM
usb_packet_ready  output  1  1 = core owns buffer
usb_control  output  16  control register value (core read / usb module input)
timed_out  output  1  sticky: watchdog fired
dropped_packets  output  8  saturating count of got_usb_packet ignored

Behaviour:
- Reset (async, rst_n=0): state USB_OWNS, usb_packet_ready=0, usb_control=0, timed_out=0, dropped_packets=0, watchdog=0, buffer_write_sections=0.
- States: USB_OWNS, CORE_OWNS, RELEASE.
- USB_OWNS: buffer_address=usb_buffer_address; sections=4'b1111 if usb_write_enable else 0; value=usb_write_value. got_usb_packet -> latch usb_control<=usb_usb_control, go CORE_OWNS; usb_packet_ready=1 from the next cycle (1-cycle latency).
- CORE_OWNS: address decode hit = BUFFER_BASE <= core_address < BUFFER_BASE+BUFFER_BYTES. buffer_address=(core_address-BUFFER_BASE)[9:2]. sections=hit ? core_write_sections : 0. usb_write_enable is ignored.
- CORE_OWNS exit: core write with core_address[31:2]==CONTROL_ADDRESS[31:2] and core_write_sections[1:0]!=0. Update the enabled bytes of usb_control[15:0]. Clear timed_out. Go RELEASE.
- RELEASE: one cycle. All sections=0 so an in-flight core buffer read completes. usb_packet_ready=0. Then USB_OWNS.
- Watchdog: counts only in CORE_OWNS, clears on entry. When count==TIMEOUT_CYCLES-1 and no control write occurs that cycle: usb_control<=16'h0, timed_out<=1, go RELEASE.
- Simultaneous watchdog expiry and control write: the write wins and timed_out is not set.
- got_usb_packet outside USB_OWNS: ignored; dropped_packets+=1, saturating at 8'hff.
- Combinational: buffer_* outputs are decoded from state and inputs. Registered: state, usb_control, counters.
- Writes to CONTROL_ADDRESS in USB_OWNS or RELEASE are ignored.

Decomposition:
- Shared package: state encoding (USB_OWNS=2'd0, CORE_OWNS=2'd1, RELEASE=2'd2) and the address constants BUFFER_BASE and CONTROL_ADDRESS, shared with top.
- One natural sub-module: usb_buffer_watchdog (counter, clear, enable, expire pulse).

Test Plan:
- Reset mid-CORE_OWNS (rst_n low for 1 cycle) -> usb_packet_ready=0, usb_control=0, dropped_packets=0 immediately (async).
- got_usb_packet with usb_usb_control=16'h1234 -> next cycle usb_packet_ready=1, usb_control=16'h1234. Core write 4'b1111 at 0xc0000008 -> buffer_address=2, sections=4'b1111.
- In CORE_OWNS, core writes 16'h00ab to 0x80000014 with sections 4'b0011 -> usb_control=16'h00ab, one RELEASE cycle with sections=0, then usb_write_enable with usb_buffer_address=5 -> buffer_address=5, sections=4'b1111.
- TIMEOUT_CYCLES=16: enter CORE_OWNS and idle -> after 16 cycles usb_control=0, timed_out=1, then USB_OWNS. The next control write clears timed_out.
- 300 got_usb_packet pulses while in CORE_OWNS -> dropped_packets=8'hff, usb_control unchanged.
- Expiry cycle coincides with control write 16'h0055 -> usb_control=16'h0055, timed_out=0.
